// File: rtl/alk_shift_seq.sv
// alk_shift_seq: sequencer for multi-step single-bit ALU shifts.
// Every step strobes the ALU result register, selects the shift direction
// and supplies the shift-in bit. It also records the last bit shifted out.
// Optional feature macro: ALK_SHIFT_SEQ_STICKY_EN. When it is defined,
// sticky_h is the OR of all bits shifted out. When it is undefined, there is
// no sticky register and sticky_h is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start_h; last_out/sticky hold previous result
// ST_SHIFT | one shift step per cycle, alu_wen_h asserted
// ST_DONE  | single-cycle done_h pulse, then back to idle
module alk_shift_seq (
    input  logic       clk_h,
    input  logic       reset_l,
    input  logic       start_h,
    input  logic       dir_shl_h,
    input  logic [4:0] count_h,
    input  logic [1:0] fill_h,
    input  logic       link_in_h,
    input  logic       alu_sout_shl_h,
    input  logic       alu_sout_shr_h,
    output logic       alu_shl_en_h,
    output logic       alu_shr_en_h,
    output logic       alu_sin_h,
    output logic       alu_wen_h,
    output logic       busy_h,
    output logic       done_h,
    output logic       last_out_h,
    output logic       sticky_h
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] FILL_ZERO  = 2'b00;
    localparam logic [1:0] FILL_ONE   = 2'b01;
    localparam logic [1:0] FILL_CHAIN = 2'b10;
    localparam logic [1:0] FILL_LINK  = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_count;
    logic       r_dir;
    logic [1:0] r_fill;
    logic       r_last_out;
    logic       r_first;

    logic       w_accept;
    logic       w_in_shift;
    logic       w_sout;
    logic       w_fill_bit;

    assign w_accept   = (r_state == ST_IDLE) && start_h;
    assign w_in_shift = (r_state == ST_SHIFT);

    // The shifted-out bit comes from whichever ALU end matches the latched direction.
    assign w_sout = r_dir ? alu_sout_shl_h : alu_sout_shr_h;

    // State register.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode. A zero count skips SHIFT and goes straight to the done pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_h) begin
                    if (count_h != 5'd0) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (r_count == 5'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the request at start. In SHIFT, count steps down and capture each shifted-out bit.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            r_count    <= 5'd0;
            r_dir      <= 1'b0;
            r_fill     <= 2'b00;
            r_last_out <= 1'b0;
            r_first    <= 1'b0;
        end else if (w_accept) begin
            r_count    <= count_h;
            r_dir      <= dir_shl_h;
            r_fill     <= fill_h;
            r_last_out <= 1'b0;
            r_first    <= 1'b1;
        end else if (w_in_shift) begin
            r_count    <= r_count - 5'd1;
            r_last_out <= w_sout;
            r_first    <= 1'b0;
        end
    end

`ifdef ALK_SHIFT_SEQ_STICKY_EN
    logic r_sticky;

    // Sticky accumulates every shifted-out bit since the last accepted start.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b0;
        end else if (w_in_shift) begin
            r_sticky <= r_sticky | w_sout;
        end
    end

    assign sticky_h = r_sticky;
`else
    assign sticky_h = 1'b0;
`endif

    // Shift-in source selection. Chain mode reuses the registered last_out rather than
    // the live ALU sout, so no combinational path runs through the ALU shift pads.
    // The first chain step has no previous bit, so it takes link_in_h instead.
    always_comb begin
        w_fill_bit = 1'b0;
        case (r_fill)
            FILL_ZERO:  w_fill_bit = 1'b0;
            FILL_ONE:   w_fill_bit = 1'b1;
            FILL_CHAIN: w_fill_bit = r_first ? link_in_h : r_last_out;
            FILL_LINK:  w_fill_bit = link_in_h;
            default:    w_fill_bit = 1'b0;
        endcase
    end

    assign alu_wen_h    = w_in_shift;
    assign alu_shl_en_h = w_in_shift && r_dir;
    assign alu_shr_en_h = w_in_shift && !r_dir;
    assign alu_sin_h    = w_in_shift && w_fill_bit;
    assign busy_h       = (r_state != ST_IDLE);
    assign done_h       = (r_state == ST_DONE);
    assign last_out_h   = r_last_out;

endmodule

// File: tb/tb_alk_shift_seq.sv
// Scoreboard bench for alk_shift_seq. Stimulus pushes the expected strobe and done
// events into a queue. A negedge monitor pops and compares them whenever the DUT
// shows alu_wen_h or done_h.
module tb_alk_shift_seq;

    logic       clk_h = 1'b0;
    logic       reset_l = 1'b1;
    logic       start_h = 1'b0;
    logic       dir_shl_h = 1'b0;
    logic [4:0] count_h = 5'd0;
    logic [1:0] fill_h = 2'b00;
    logic       link_in_h = 1'b0;
    logic       alu_sout_shl_h = 1'b0;
    logic       alu_sout_shr_h = 1'b0;
    logic       alu_shl_en_h;
    logic       alu_shr_en_h;
    logic       alu_sin_h;
    logic       alu_wen_h;
    logic       busy_h;
    logic       done_h;
    logic       last_out_h;
    logic       sticky_h;

`ifdef ALK_SHIFT_SEQ_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct {
        bit is_done;
        int cyc;
        bit shl;
        bit shr;
        bit sin;
        bit last;
        bit sticky;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    alk_shift_seq dut (
        .clk_h          (clk_h),
        .reset_l        (reset_l),
        .start_h        (start_h),
        .dir_shl_h      (dir_shl_h),
        .count_h        (count_h),
        .fill_h         (fill_h),
        .link_in_h      (link_in_h),
        .alu_sout_shl_h (alu_sout_shl_h),
        .alu_sout_shr_h (alu_sout_shr_h),
        .alu_shl_en_h   (alu_shl_en_h),
        .alu_shr_en_h   (alu_shr_en_h),
        .alu_sin_h      (alu_sin_h),
        .alu_wen_h      (alu_wen_h),
        .busy_h         (busy_h),
        .done_h         (done_h),
        .last_out_h     (last_out_h),
        .sticky_h       (sticky_h)
    );

    always #5 clk_h = ~clk_h;

    always @(posedge clk_h) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per presented strobe or done pulse.
    always @(negedge clk_h) begin
        exp_t e;
        if (reset_l === 1'b1) begin
            if (alu_wen_h === 1'b1 || done_h === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {30'd0, alu_wen_h, done_h}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("busy_active", busy_h, 1);
                    if (!e.is_done) begin
                        check("strobe_not_done", done_h, 0);
                        check("shl_en", alu_shl_en_h, e.shl);
                        check("shr_en", alu_shr_en_h, e.shr);
                        check("sin", alu_sin_h, e.sin);
                    end else begin
                        check("done_no_wen", alu_wen_h, 0);
                        check("last_out", last_out_h, e.last);
                        check("sticky", sticky_h, e.sticky);
                    end
                end
            end else begin
                check("idle_router", {29'd0, alu_shl_en_h, alu_shr_en_h, alu_sin_h}, 32'd0);
            end
        end
    end

    // Drive from the post-edge point; expectations use the cycle count seen by the monitor.
    task automatic run_seq(input bit dir, input int n, input bit [1:0] fill,
                           input bit [31:0] link, input bit [31:0] sout, input bit hold_start);
        int   c;
        bit   last;
        bit   stk;
        bit   sin;
        exp_t e;
        c    = cyc;
        last = 1'b0;
        stk  = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (fill)
                2'b00:   sin = 1'b0;
                2'b01:   sin = 1'b1;
                2'b10:   sin = (i == 0) ? link[0] : last;
                default: sin = link[i];
            endcase
            e = '{is_done: 1'b0, cyc: c + 1 + i, shl: dir, shr: !dir, sin: sin, last: 1'b0, sticky: 1'b0};
            q.push_back(e);
            last = sout[i];
            stk  = stk | sout[i];
        end
        e = '{is_done: 1'b1, cyc: c + 1 + n, shl: 1'b0, shr: 1'b0, sin: 1'b0, last: last, sticky: stk & STICKY_ON};
        q.push_back(e);
        start_h   = 1'b1;
        dir_shl_h = dir;
        count_h   = n[4:0];
        fill_h    = fill;
        @(posedge clk_h); #1;
        start_h   = hold_start;
        dir_shl_h = ~dir;
        count_h   = ~n[4:0];
        fill_h    = ~fill;
        for (int i = 0; i < n; i++) begin
            link_in_h      = link[i];
            alu_sout_shl_h = dir ? sout[i] : ~sout[i];
            alu_sout_shr_h = dir ? ~sout[i] : sout[i];
            @(posedge clk_h); #1;
        end
        start_h = 1'b0;
        @(posedge clk_h); #1;
        check("idle_after_done", busy_h, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        exp_t e;
        #2 reset_l = 1'b0;
        #1;
        check("rst_wen", alu_wen_h, 0);
        check("rst_busy", busy_h, 0);
        check("rst_done", done_h, 0);
        check("rst_dirs", {alu_shl_en_h, alu_shr_en_h, alu_sin_h}, 0);
        check("rst_last_sticky", {last_out_h, sticky_h}, 0);
        repeat (2) @(posedge clk_h);
        #1 reset_l = 1'b1;
        @(posedge clk_h); #1;

        // Left, fill one, sout 1,0,1: sin=1 each step, last_out=1, sticky=1.
        run_seq(1'b1, 3, 2'b01, 32'd0, 32'b101, 1'b0);
        repeat (3) @(posedge clk_h);
        #1;
        check("hold_last_out", last_out_h, 1);
        check("hold_sticky", sticky_h, STICKY_ON);

        // Zero count: only a done pulse, last_out/sticky cleared.
        run_seq(1'b0, 0, 2'b01, 32'd0, 32'd0, 1'b0);

        // Right, chain fill, link=1, sout 0,1,1,0: sin=1,0,1,1, last_out=0.
        run_seq(1'b0, 4, 2'b10, 32'hFFFF_FFFF, 32'b0110, 1'b0);

        // Left chain with link_in=0 on the first step; sout 1,1,0.
        run_seq(1'b1, 3, 2'b10, 32'd0, 32'b011, 1'b0);

        // Right, link fill following a link_in pattern, start held while busy (ignored).
        run_seq(1'b0, 5, 2'b11, 32'b10110, 32'b01001, 1'b1);

        // Maximum count, zero fill, no ones shifted out.
        run_seq(1'b1, 31, 2'b00, 32'hA5A5_A5A5, 32'd0, 1'b0);

        // Back-to-back: start held high, count 2; one idle cycle between done and next strobe.
        c = cyc;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) begin
                e = '{is_done: 1'b0, cyc: c + 1 + 4 * s + i, shl: 1'b0, shr: 1'b1, sin: 1'b0, last: 1'b0, sticky: 1'b0};
                q.push_back(e);
            end
            e = '{is_done: 1'b1, cyc: c + 3 + 4 * s, shl: 1'b0, shr: 1'b0, sin: 1'b0, last: 1'b0, sticky: 1'b0};
            q.push_back(e);
        end
        start_h        = 1'b1;
        dir_shl_h      = 1'b0;
        count_h        = 5'd2;
        fill_h         = 2'b00;
        alu_sout_shl_h = 1'b1;
        alu_sout_shr_h = 1'b0;
        repeat (4) @(posedge clk_h);
        #1;
        check("b2b_idle_gap", busy_h, 0);
        @(posedge clk_h); #1;
        start_h = 1'b0;
        repeat (3) @(posedge clk_h);
        #1;
        check("b2b_idle_end", busy_h, 0);

        // Reset mid-sequence: count 5, reset after two strobes, no done pulse.
        c = cyc;
        for (int i = 0; i < 2; i++) begin
            e = '{is_done: 1'b0, cyc: c + 1 + i, shl: 1'b1, shr: 1'b0, sin: 1'b1, last: 1'b0, sticky: 1'b0};
            q.push_back(e);
        end
        start_h        = 1'b1;
        dir_shl_h      = 1'b1;
        count_h        = 5'd5;
        fill_h         = 2'b01;
        alu_sout_shl_h = 1'b1;
        alu_sout_shr_h = 1'b0;
        @(posedge clk_h); #1;
        start_h = 1'b0;
        @(posedge clk_h); #1;
        @(posedge clk_h); #1;
        reset_l = 1'b0;
        #1;
        check("abort_wen", alu_wen_h, 0);
        check("abort_busy", busy_h, 0);
        check("abort_done", done_h, 0);
        check("abort_dirs", {alu_shl_en_h, alu_shr_en_h, alu_sin_h}, 0);
        check("abort_last_sticky", {last_out_h, sticky_h}, 0);
        repeat (2) @(posedge clk_h);
        #1 reset_l = 1'b1;
        repeat (3) @(posedge clk_h);
        #1;
        check("abort_idle", busy_h, 0);

        // Recovery after abort.
        run_seq(1'b0, 2, 2'b01, 32'd0, 32'b01, 1'b0);

        repeat (3) @(posedge clk_h);
        #1;
        check("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alk_shift_seq.md
ALK_SHIFT_SEQ -- requirements
Module: alk_shift_seq

Interface
REQ-001 One clock; reset is asynchronous and active-low; ports SHALL be: clk_h  in  1  datapath clock, rising-edge; reset_l  in  1  async active-low reset.
REQ-002 start_h  in  1  request a shift sequence, sampled only in IDLE.
REQ-003 dir_shl_h  in  1  1 = shift left, 0 = shift right; latched at start.
REQ-004 count_h  in  5  number of single-bit shift steps, 0..31; latched at start.
REQ-005 fill_h  in  2  shift-in source: 00 zero, 01 one, 10 chain, 11 link; latched at start.
REQ-006 link_in_h  in  1  external fill bit (Q-side or neighbour slice), sampled every SHIFT cycle.
REQ-007 alu_sout_shl_h  in  1  bit leaving the ALU on a left shift (ALU[31] side).
REQ-008 alu_sout_shr_h  in  1  bit leaving the ALU on a right shift (ALU[0] side).
REQ-009 alu_shl_en_h / alu_shr_en_h  out  1 each  per-step shift-direction enables to the ALU shift-in/out router.
REQ-010 alu_sin_h  out  1  bit shifted into the ALU this step.
REQ-011 alu_wen_h  out  1  ALU result register write strobe, one per step.
REQ-012 busy_h  out  1  sequence in progress; done_h  out  1  one-cycle completion pulse.
REQ-013 last_out_h  out  1  last bit shifted out; sticky_h  out  1  OR of all bits shifted out (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015 IDLE: start_h=1 and count_h!=0 -> latch dir/count/fill, clear last_out and sticky, go SHIFT; start_h=1 and count_h=0 -> go DONE, no shift step, last_out/sticky cleared.
REQ-016 SHIFT: each cycle assert alu_wen_h=1 and exactly one of alu_shl_en_h (dir=1) / alu_shr_en_h (dir=0); both SHALL be 0 outside SHIFT.
REQ-017 SHIFT: at clock edge, last_out <= sout of latched direction; step counter decrements; counter==1 at edge -> DONE.
REQ-018 alu_sin_h in SHIFT: fill 00 -> 0; 01 -> 1; 10 (chain) -> registered last_out (first step uses link_in_h); 11 -> link_in_h; alu_sin_h SHALL be 0 outside SHIFT.
REQ-019 alu_sin_h SHALL NOT depend combinationally on alu_sout_* (no loop through ALU_SIO pads).
REQ-020 DONE: done_h=1 for exactly one cycle, then IDLE; busy_h=1 in SHIFT and DONE, 0 in IDLE.
REQ-021 Latency: count N>0 accepted at edge k -> N strobe cycles k+1..k+N, done_h in cycle k+N+1; count 0 -> done_h in cycle k+1.
REQ-022 start_h while busy_h=1 SHALL be ignored (no re-latch, no queueing).
REQ-023 last_out_h and sticky_h SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-024 reset_l=0 SHALL immediately force IDLE; all outputs 0, counter 0, latched dir/fill 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort with no further alu_wen_h and no done_h pulse.

Configuration
REQ-026 Macro ALK_SHIFT_SEQ_STICKY_EN defined: sticky <= sticky | shifted-out bit each SHIFT step, sticky_h driven from it.
REQ-027 ALK_SHIFT_SEQ_STICKY_EN undefined: no sticky register; sticky_h tied 0; all other behaviour identical.

Verification
REQ-028 Reset mid-sequence: start count=5, assert reset_l=0 after 2 strobes -> outputs 0 immediately, no done_h, IDLE after release.
REQ-029 Left, fill 01, count=3, alu_sout_shl_h=1,0,1 -> alu_shl_en_h/alu_wen_h high 3 cycles, alu_sin_h=1, done_h 4th cycle, last_out_h=1, sticky_h=1 (0 if macro off).
REQ-030 Right, fill 10, count=4, link_in_h=1, alu_sout_shr_h=0,1,1,0 -> alu_sin_h=1,0,1,1, last_out_h=0.
REQ-031 count=0 start -> no alu_wen_h, done_h next cycle, busy_h high 1 cycle.
REQ-032 start_h held high continuously, count=2 -> sequences back-to-back with one IDLE cycle between done_h and next first strobe.
REQ-033 count=31, fill 00, sout all 0 -> 31 strobes, alu_sin_h=0 throughout, sticky_h=0, done_h cycle 32.
